// File: rtl/dly_cmd_pkg.sv
// Shared types and helpers for the delay-line command sequencer.
// Command bit layout is {load, adj, incdec}, matching each dly_cntrl slice.
package dly_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } seq_state_e;

    localparam int CMD_LOAD   = 2;
    localparam int CMD_ADJ    = 1;
    localparam int CMD_INCDEC = 0;

    // All-ones address of the given width selects every channel.
    function automatic logic is_bcast(input logic [31:0] addr, input int aw);
        return addr == (32'hFFFF_FFFF >> (32 - aw));
    endfunction

endpackage

// File: rtl/dly_tap_shadow.sv
// Shadow copy of one delay line's tap setting: load, or saturating +1/-1.
module dly_tap_shadow #(
    parameter int TAP_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic                 adj,
    input  logic                 incdec,
    input  logic [TAP_WIDTH-1:0] tap_in,
    output logic [TAP_WIDTH-1:0] tap
);

    localparam logic [TAP_WIDTH-1:0] TAP_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap <= '0;
        end else if (en) begin
            if (load) begin
                tap <= tap_in;
            end else if (adj) begin
                if (incdec) begin
                    if (tap != TAP_MAX) tap <= tap + 1'b1;
                end else begin
                    if (tap != '0) tap <= tap - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dly_cmd_sequencer.sv
// Accepts one delay-line command at a time, pulses the addressed control
// slice(s) for one cycle, tracks tap shadows, then idles for a settle gap.
import dly_cmd_pkg::*;

module dly_cmd_sequencer #(
    parameter int NUM_DLY       = 20,
    parameter int ADDR_WIDTH    = 5,
    parameter int TAP_WIDTH     = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   dly_load,
    input  logic                   dly_adj,
    input  logic                   dly_incdec,
    input  logic [ADDR_WIDTH-1:0]  dly_addr,
    input  logic [TAP_WIDTH-1:0]   dly_tap_in,
    output logic [3*NUM_DLY-1:0]   dly_cntrl,
    input  logic [ADDR_WIDTH-1:0]  tap_rd_addr,
    output logic [TAP_WIDTH-1:0]   tap_rd_data,
    output logic                   cmd_err,
    output logic                   busy
);

    localparam logic [ADDR_WIDTH:0] NUM_DLY_W = (ADDR_WIDTH + 1)'(NUM_DLY);
    localparam logic [3:0]          SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

    seq_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [2:0]            cmd_bits, cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TAP_WIDTH-1:0]  tap_q;
    logic                  cmd_bcast, bcast_q, cmd_legal, accept, accept_ok;

    logic [NUM_DLY-1:0][2:0]           cntrl_q, cntrl_d;
    logic [NUM_DLY-1:0][TAP_WIDTH-1:0] shadow;

    assign cmd_bits  = {dly_load, dly_adj, dly_incdec};
    assign cmd_bcast = is_bcast(32'(dly_addr), ADDR_WIDTH);
    assign cmd_legal = cmd_bcast || ({1'b0, dly_addr} < NUM_DLY_W);
    assign accept    = (state_q == ST_IDLE) && cmd_valid && cmd_ready;
    assign accept_ok = accept && cmd_legal;
    assign bcast_q   = is_bcast(32'(addr_q), ADDR_WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_ok) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_M1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control slices are loaded at acceptance so they are live exactly during ISSUE.
    always_comb begin
        cntrl_d = '0;
        for (int k = 0; k < NUM_DLY; k++) begin
            if (accept_ok && (cmd_bcast || dly_addr == ADDR_WIDTH'(k)))
                cntrl_d[k] = cmd_bits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            cmd_err   <= 1'b0;
            cntrl_q   <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            tap_q     <= '0;
        end else begin
            cmd_ready <= (state_d == ST_IDLE);
            cmd_err   <= accept && !cmd_legal;
            cntrl_q   <= cntrl_d;
            if (accept_ok) begin
                cmd_q  <= cmd_bits;
                addr_q <= dly_addr;
                tap_q  <= dly_tap_in;
            end
        end
    end

    for (genvar k = 0; k < NUM_DLY; k++) begin : g_ch
        logic hit;
        assign hit = bcast_q || (addr_q == ADDR_WIDTH'(k));

        dly_tap_shadow #(.TAP_WIDTH(TAP_WIDTH)) u_shadow (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     ((state_q == ST_ISSUE) && hit),
            .load   (cmd_q[CMD_LOAD]),
            .adj    (cmd_q[CMD_ADJ]),
            .incdec (cmd_q[CMD_INCDEC]),
            .tap_in (tap_q),
            .tap    (shadow[k])
        );
    end

    always_comb begin
        tap_rd_data = '0;
        for (int k = 0; k < NUM_DLY; k++) begin
            if (tap_rd_addr == ADDR_WIDTH'(k)) tap_rd_data = shadow[k];
        end
    end

    assign dly_cntrl = cntrl_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dly_cmd_sequencer.sv
// Directed checks of the delay command sequencer; a second instance with a
// zero settle gap covers back-to-back acceptance.
module tb_dly_cmd_sequencer;

    logic        clk, rst_n;
    logic        cmd_valid, dly_load, dly_adj, dly_incdec;
    logic [4:0]  dly_addr, tap_rd_addr;
    logic [5:0]  dly_tap_in;

    logic        cmd_ready, cmd_err, busy;
    logic [59:0] dly_cntrl;
    logic [5:0]  tap_rd_data;

    logic        cmd_ready0, cmd_err0, busy0;
    logic [59:0] dly_cntrl0;
    logic [5:0]  tap_rd_data0;

    int n_cmp = 0;
    int n_bad = 0;

    dly_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .dly_load(dly_load), .dly_adj(dly_adj), .dly_incdec(dly_incdec),
        .dly_addr(dly_addr), .dly_tap_in(dly_tap_in), .dly_cntrl(dly_cntrl),
        .tap_rd_addr(tap_rd_addr), .tap_rd_data(tap_rd_data),
        .cmd_err(cmd_err), .busy(busy)
    );

    dly_cmd_sequencer #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .dly_load(dly_load), .dly_adj(dly_adj), .dly_incdec(dly_incdec),
        .dly_addr(dly_addr), .dly_tap_in(dly_tap_in), .dly_cntrl(dly_cntrl0),
        .tap_rd_addr(tap_rd_addr), .tap_rd_data(tap_rd_data0),
        .cmd_err(cmd_err0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge of cycle N+1.
    task automatic send(input logic l, input logic a, input logic i,
                        input logic [4:0] addr, input logic [5:0] tap);
        cmd_valid = 1'b1; dly_load = l; dly_adj = a; dly_incdec = i;
        dly_addr = addr; dly_tap_in = tap;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
        n_cmp++; if (dly_cntrl !== 60'd0) begin n_bad++; $display("FAIL rst_cntrl: got %h want 0", dly_cntrl); end
        n_cmp++; if ({busy, cmd_err} !== 2'b00) begin n_bad++; $display("FAIL rst_busy_err: got %b want 00", {busy, cmd_err}); end
        n_cmp++; if (tap_rd_data !== 6'd0) begin n_bad++; $display("FAIL rst_tap: got %0d want 0", tap_rd_data); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rel_ready_early: got %b want 0", cmd_ready); end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_load();
        logic [59:0] exp;
        exp = '0; exp[11:9] = 3'b100;
        tap_rd_addr = 5'd3;
        send(1'b1, 1'b0, 1'b0, 5'd3, 6'd17);
        n_cmp++; if (dly_cntrl !== exp) begin n_bad++; $display("FAIL load_cntrl: got %h want %h", dly_cntrl, exp); end
        n_cmp++; if ({busy, cmd_ready} !== 2'b10) begin n_bad++; $display("FAIL load_busy: got %b want 10", {busy, cmd_ready}); end
        n_cmp++; if (tap_rd_data !== 6'd0) begin n_bad++; $display("FAIL load_tap_early: got %0d want 0", tap_rd_data); end
        @(negedge clk);
        n_cmp++; if (dly_cntrl !== 60'd0) begin n_bad++; $display("FAIL load_cntrl_off: got %h want 0", dly_cntrl); end
        n_cmp++; if (tap_rd_data !== 6'd17) begin n_bad++; $display("FAIL load_tap: got %0d want 17", tap_rd_data); end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_n3: got %b want 0", cmd_ready); end
        @(negedge clk);
        n_cmp++; if ({busy, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL load_ready_n4: got %b want 01", {busy, cmd_ready}); end
    endtask

    task automatic test_saturate();
        logic [59:0] exp;
        exp = '0; exp[17:15] = 3'b011;
        tap_rd_addr = 5'd5;
        send(1'b1, 1'b0, 1'b0, 5'd5, 6'd62);
        repeat (3) @(negedge clk);
        n_cmp++; if (tap_rd_data !== 6'd62) begin n_bad++; $display("FAIL sat_load: got %0d want 62", tap_rd_data); end
        for (int n = 0; n < 3; n++) begin
            send(1'b0, 1'b1, 1'b1, 5'd5, 6'd0);
            n_cmp++; if (dly_cntrl !== exp) begin n_bad++; $display("FAIL sat_cntrl%0d: got %h want %h", n, dly_cntrl, exp); end
            repeat (3) @(negedge clk);
            n_cmp++; if (tap_rd_data !== 6'd63) begin n_bad++; $display("FAIL sat_tap%0d: got %0d want 63", n, tap_rd_data); end
            n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL sat_ready%0d: got %b want 1", n, cmd_ready); end
        end
    endtask

    task automatic test_err();
        tap_rd_addr = 5'd3;
        send(1'b1, 1'b0, 1'b0, 5'd25, 6'd7);
        n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %b want 1", cmd_err); end
        n_cmp++; if (dly_cntrl !== 60'd0) begin n_bad++; $display("FAIL err_cntrl: got %h want 0", dly_cntrl); end
        n_cmp++; if ({busy, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL err_ready: got %b want 01", {busy, cmd_ready}); end
        @(negedge clk);
        n_cmp++; if ({cmd_err, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL err_after: got %b want 01", {cmd_err, cmd_ready}); end
        n_cmp++; if (tap_rd_data !== 6'd17) begin n_bad++; $display("FAIL err_shadow3: got %0d want 17", tap_rd_data); end
        tap_rd_addr = 5'd25;
        #1;
        n_cmp++; if (tap_rd_data !== 6'd0) begin n_bad++; $display("FAIL err_rd_oor: got %0d want 0", tap_rd_data); end
    endtask

    task automatic test_broadcast();
        logic [59:0] exp;
        exp = {20{3'b010}};
        @(negedge clk);
        do_reset();
        send(1'b0, 1'b1, 1'b0, 5'd31, 6'd0);
        n_cmp++; if (dly_cntrl !== exp) begin n_bad++; $display("FAIL bc_cntrl: got %h want %h", dly_cntrl, exp); end
        @(negedge clk);
        n_cmp++; if (dly_cntrl !== 60'd0) begin n_bad++; $display("FAIL bc_cntrl_off: got %h want 0", dly_cntrl); end
        for (int k = 0; k < 20; k++) begin
            tap_rd_addr = 5'(k);
            #1;
            n_cmp++; if (tap_rd_data !== 6'd0) begin n_bad++; $display("FAIL bc_tap%0d: got %0d want 0", k, tap_rd_data); end
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL bc_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_reset_settle();
        tap_rd_addr = 5'd0;
        send(1'b1, 1'b0, 1'b0, 5'd0, 6'd9);
        @(negedge clk);
        n_cmp++; if (tap_rd_data !== 6'd9) begin n_bad++; $display("FAIL rs_tap_pre: got %0d want 9", tap_rd_data); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tap_rd_data !== 6'd0) begin n_bad++; $display("FAIL rs_tap: got %0d want 0", tap_rd_data); end
        n_cmp++; if ({busy, cmd_ready} !== 2'b00) begin n_bad++; $display("FAIL rs_ready: got %b want 00", {busy, cmd_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rs_ready_rel: got %b want 0", cmd_ready); end
        @(negedge clk);
        n_cmp++; if ({busy, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL rs_ready_edge: got %b want 01", {busy, cmd_ready}); end
        n_cmp++; if (tap_rd_data !== 6'd0) begin n_bad++; $display("FAIL rs_tap_post: got %0d want 0", tap_rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [59:0] exp;
        do_reset();
        cmd_valid = 1'b1; dly_load = 1'b1; dly_adj = 1'b0; dly_incdec = 1'b0;
        dly_addr = 5'd0; dly_tap_in = 6'd1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = '0;
            if (k % 2 == 0) exp[3*k +: 3] = 3'b100;
            n_cmp++; if (dly_cntrl0 !== exp) begin n_bad++; $display("FAIL b2b_cntrl%0d: got %h want %h", k, dly_cntrl0, exp); end
            n_cmp++; if ({busy0, cmd_ready0} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL b2b_ready%0d: got %b", k, {busy0, cmd_ready0});
            end
            dly_addr = 5'(k + 1); dly_tap_in = 6'(k + 2);
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tap_rd_addr = 5'(k);
            #1;
            n_cmp++; if (tap_rd_data0 !== ((k % 2 == 0) ? 6'(k + 1) : 6'd0)) begin
                n_bad++; $display("FAIL b2b_tap%0d: got %0d", k, tap_rd_data0);
            end
        end
        n_cmp++; if (cmd_err0 !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b want 0", cmd_err0); end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; dly_load = 1'b0; dly_adj = 1'b0; dly_incdec = 1'b0;
        dly_addr = '0; dly_tap_in = '0; tap_rd_addr = '0;
        test_reset();
        test_load();
        test_saturate();
        test_err();
        test_broadcast();
        test_reset_settle();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dly_cmd_sequencer.md
DLY_CMD_SEQUENCER -- requirements
Module: DLY_CMD_SEQUENCER

Interface
REQ-001 SHALL have parameter NUM_DLY, default 20, number of delay channels, legal 1..2**ADDR_WIDTH-1.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, command and readback address width.
REQ-003 SHALL have parameter TAP_WIDTH, default 6, shadow tap counter width.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2, idle gap after each issued command, legal 0..15.
REQ-005 SHALL have port CLK  in  1  sole clock, all flops rising-edge.
REQ-006 SHALL have port RST_N  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port CMD_VALID  in  1  command offered.
REQ-008 SHALL have port CMD_READY  out  1  command accepted when high with CMD_VALID.
REQ-009 SHALL have ports DLY_LOAD, DLY_ADJ, DLY_INCDEC  in  1 each  command bits.
REQ-010 SHALL have port DLY_ADDR  in  ADDR_WIDTH  target channel; all-ones = broadcast.
REQ-011 SHALL have port DLY_TAP_IN  in  TAP_WIDTH  load value for shadow counter.
REQ-012 SHALL have port DLY_CNTRL  out  3*NUM_DLY  registered per-channel {LOAD,ADJ,INCDEC}, channel k at bits [3k+2:3k].
REQ-013 SHALL have port TAP_RD_ADDR  in  ADDR_WIDTH  shadow readback select.
REQ-014 SHALL have port TAP_RD_DATA  out  TAP_WIDTH  combinational shadow value; 0 for out-of-range address.
REQ-015 SHALL have port CMD_ERR  out  1  one-cycle pulse on illegal address.
REQ-016 SHALL have port BUSY  out  1  high whenever FSM not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, SETTLE; CMD_READY high only in IDLE (registered).
REQ-018 SHALL latch command and address on CMD_VALID&&CMD_READY in IDLE and move to ISSUE.
REQ-019 SHALL, in ISSUE, drive the addressed DLY_CNTRL slice (all slices if broadcast) with latched bits for exactly one cycle; all other slices 3'b000 at all times.
REQ-020 SHALL transition ISSUE->SETTLE, count SETTLE_CYCLES cycles, then IDLE; with SETTLE_CYCLES=0, ISSUE->IDLE directly.
REQ-021 SHALL give latency: accept at edge N, DLY_CNTRL valid in cycle N+1, CMD_READY high again at cycle N+2+SETTLE_CYCLES.
REQ-022 SHALL, for address >= NUM_DLY and not all-ones, skip ISSUE, remain IDLE, pulse CMD_ERR in cycle after acceptance, leave outputs/shadows unchanged.
REQ-023 SHALL update shadows at end of ISSUE: LOAD=1 -> DLY_TAP_IN (LOAD beats ADJ); else ADJ=1,INCDEC=1 -> +1 saturating at 2**TAP_WIDTH-1; ADJ=1,INCDEC=0 -> -1 saturating at 0; LOAD=ADJ=0 -> no change but still issued.
REQ-024 SHALL pass raw command bits to DLY_CNTRL regardless of LOAD/ADJ priority.
REQ-025 SHALL ignore CMD_VALID and all command inputs while not IDLE.
REQ-026 SHALL reflect a shadow update on TAP_RD_DATA in the cycle after ISSUE.

Reset
REQ-027 SHALL, with RST_N low, force FSM IDLE, CMD_READY 0, DLY_CNTRL 0, CMD_ERR 0, BUSY 0, all shadows 0, settle counter 0.
REQ-028 SHALL assert CMD_READY at the first CLK edge after RST_N deasserts.
REQ-029 SHALL, on reset mid-ISSUE or mid-SETTLE, abandon the command with no shadow update.

Structure
REQ-030 SHALL place state enum, command bit indices (LOAD=2, ADJ=1, INCDEC=0) and broadcast-address function in shared package dly_cmd_pkg.
REQ-031 SHALL instantiate NUM_DLY copies of sub-module DLY_TAP_SHADOW (one saturating load/inc/dec counter) via generate.

Verification
REQ-032 SHALL test: reset release, cmd LOAD=1 addr 3 tap 17 -> DLY_CNTRL[11:9]=3'b100 one cycle at N+1, TAP_RD_DATA(3)=17, CMD_READY at N+4.
REQ-033 SHALL test: addr 5 tap 62 load, then three ADJ/INC commands -> DLY_CNTRL[17:15]=3'b011 each time, shadow 63 after third (saturated).
REQ-034 SHALL test: addr 31 broadcast ADJ/DEC after reset -> all 20 slices 3'b010 same cycle, all shadows stay 0.
REQ-035 SHALL test: addr 25 -> CMD_ERR one pulse, DLY_CNTRL stays 0, CMD_READY never drops.
REQ-036 SHALL test: RST_N low during SETTLE after LOAD addr 0 tap 9 -> shadow 0, CMD_READY 0 then 1 at first edge after release.
REQ-037 SHALL test: SETTLE_CYCLES=0 back-to-back CMD_VALID -> one accept every 2 cycles, no dropped or duplicated DLY_CNTRL pulses.
